// File: rtl/uart_pkg.sv
// Shared UART definitions, used by uart_rx and uart_tx.
//   state_e          : receiver/transmitter state encoding (3 bits)
//   DATA_BITS_DEF    : default payload width
//   CLKS_PER_BIT_DEF : default clk cycles per bit (12 MHz / 9600 baud)
package uart_pkg;

  localparam int DATA_BITS_DEF    = 8;
  localparam int CLKS_PER_BIT_DEF = 1250;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : sampling clock
//   rst : async active-high reset, both flops go to 1 (UART idle level)
//   d   : asynchronous input
//   q   : synchronized output, 2 cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1-style framing, LSB first, mid-bit sampling.
//   clk       : clock
//   rst       : async active-high reset
//   rx        : asynchronous serial line, idle high
//   data      : last correctly framed word
//   valid     : one-cycle pulse when data is updated
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   busy      : high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // Re-check the line at mid start bit; a high level means a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        // Counting a full bit from mid start bit lands on mid data bit.
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == LAST_IDX) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        // Leaving at mid stop bit leaves half a bit of slack to catch a
        // back-to-back start edge.
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_BREAK: begin
        // Wait out a held-low line so it is not mistaken for a start bit.
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 1250, gives clk cycles per UART bit (12 MHz / 9600 baud); legal range 4..65535.
- REQ-002: Parameter DATA_BITS, default 8, gives the payload bits per frame.
- REQ-003: Port clk, input, 1 bit, is the single clock; every register is clocked on its rising edge.
- REQ-004: Port rst, input, 1 bit, is the reset: asynchronous and active-high.
- REQ-005: Port rx, input, 1 bit, is the serial line: asynchronous, idle high, frame format 8N1 (8 data bits, no parity, 1 stop bit), LSB first.
- REQ-006: Port data, output, DATA_BITS bits, holds the last correctly framed byte.
- REQ-007: Port valid, output, 1 bit, pulses for one cycle when data is updated.
- REQ-008: Port frame_err, output, 1 bit, pulses for one cycle when a stop bit is sampled low.
- REQ-009: Port busy, output, 1 bit, is high in every state except IDLE.

Function
- REQ-010: rx shall pass through a 2-flop synchronizer before any use; rx_s denotes the synchronized value; this gives 2 cycles of input latency.
- REQ-011: States shall be IDLE, START, DATA, STOP and BREAK.
- REQ-012: A single 16-bit cycle counter (cnt) and a 3-bit bit index (idx) shall sequence all timing.
- REQ-013: IDLE -> START on the first cycle rx_s = 0; cnt shall clear to 0 on that transition.
- REQ-014: In START at cnt = CLKS_PER_BIT/2 - 1 (integer division):
  - if rx_s = 1 (false start / glitch), go to IDLE with no output pulse;
  - otherwise go to DATA with cnt = 0 and idx = 0.
- REQ-015: In DATA, each time cnt = CLKS_PER_BIT - 1:
  - sample rx_s into shift register bit idx;
  - clear cnt;
  - increment idx;
  - after sampling bit DATA_BITS-1, go to STOP.
- REQ-016: In STOP at cnt = CLKS_PER_BIT - 1:
  - if rx_s = 1, load data from the shift register, pulse valid, and go to IDLE;
  - if rx_s = 0, pulse frame_err, leave data unchanged, and go to BREAK.
- REQ-017: BREAK shall go to IDLE on the first cycle rx_s = 1; no other output is produced while in BREAK.
- REQ-018: valid and frame_err shall never be high in the same cycle, and each is high for exactly one cycle per frame.
- REQ-019: The start-edge-to-valid latency shall be 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles, within ±1 cycle.
- REQ-020: Back-to-back frames, where the next start bit follows the stop bit immediately, shall be received without loss, because the STOP -> IDLE transition happens at mid-stop-bit.
- REQ-021: data shall hold its value until the next valid frame; no consumer handshake exists, so software/logic must read data within one frame time.
- REQ-022: cnt shall never wrap: every state clears it on the terminal count.

Reset
- REQ-023: While rst = 1 the block shall be in IDLE with synchronizer flops = 1, cnt = 0, idx = 0, shift register = 0, data = 0, valid = 0, frame_err = 0, and busy = 0.
- REQ-024: Reset asserted mid-frame shall abort the frame immediately with no pulse; after release, reception shall resume at the next falling edge of rx_s.

Structure
- REQ-025: Shared package uart_pkg shall hold the state encoding (enumerated, 3 bits), DATA_BITS_DEF = 8, and CLKS_PER_BIT_DEF = 1250, for reuse by uart_tx.
- REQ-026: One sub-module, sync_2ff (1-bit synchronizer, reset value 1), shall implement REQ-010; all other logic stays flat in uart_rx.

Verification (bench uses CLKS_PER_BIT = 16)
- REQ-027: Frame 0x48 -> data = 0x48, a single valid pulse at 2+8+9*16 = 154 ±1 cycles after the start edge, frame_err never high.
- REQ-028: rx low for 4 cycles then high -> no valid, no frame_err, busy returns to 0 by cycle 2+8+1.
- REQ-029: Frame 0x3C with the stop bit held low for 40 cycles -> one frame_err pulse, data unchanged, busy high until 1 cycle after rx_s returns high.
- REQ-030: Back-to-back 0x55 then 0xAA with zero idle gap -> two valid pulses with data 0x55 then 0xAA.
- REQ-031: rst pulsed during bit 4 of 0xFF, then frame 0x81 -> no pulse for the aborted frame, then data = 0x81 with valid.
- REQ-032: Loopback with uart_tx at the same CLKS_PER_BIT, 256 random bytes -> every byte received in order, zero frame_err.
